// File: rtl/coverage_reporter_pkg.sv
// Shared definitions for the fault-coverage reporter.
//   state_t  : reporter FSM states (same encoding the BIST controller uses)
//   PERMILLE : full-scale coverage value
package coverage_reporter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DIVIDE  = 2'd2,
    FIN     = 2'd3
  } state_t;

  localparam int PERMILLE = 1000;

endpackage

// File: rtl/coverage_reporter_sync_fifo.sv
// Show-ahead synchronous FIFO, reused by the ORA for mismatch logging.
//   clk, rst    : clock, async active-high reset
//   push, din   : write request / data (dropped when full without a same-cycle pop)
//   pop         : read request (ignored when empty)
//   dout        : head entry, valid whenever !empty (0 when empty)
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/coverage_reporter.sv
// Fault-coverage reporter downstream of the BIST controller/ORA.
// Counts injected and detected faults, logs undetected fault indices, and on
// the rising edge of FIL_END computes coverage in permille with a restoring
// divider, then holds DONE until reset.
//   clk, rst     : clock, async active-high reset
//   FIL_INC      : fault finished pulse; DETECT qualifies it
//   FIL_END      : injection complete (level; rising edge starts the divide)
//   UNDET_POP    : pop head of undetected-fault log
//   UNDET_VALID/UNDET_IDX/UNDET_OVF : log status, head, sticky overflow
//   DET_COUNT/TOT_COUNT : saturating fault counters
//   COVERAGE/DONE       : floor(DET*1000/TOT), valid once DONE is high
module coverage_reporter
  import coverage_reporter_pkg::*;
#(
  parameter int ERR_BITS   = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int COV_BITS   = 10
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                FIL_INC,
  input  logic                DETECT,
  input  logic                FIL_END,
  input  logic                UNDET_POP,
  output logic                UNDET_VALID,
  output logic [ERR_BITS-1:0] UNDET_IDX,
  output logic                UNDET_OVF,
  output logic [ERR_BITS-1:0] DET_COUNT,
  output logic [ERR_BITS-1:0] TOT_COUNT,
  output logic [COV_BITS-1:0] COVERAGE,
  output logic                DONE
);

  localparam int DW    = ERR_BITS + 10;        // holds DET*1000
  localparam int ITERS = ERR_BITS + COV_BITS;
  localparam int IW    = $clog2(ITERS);
  localparam logic [ERR_BITS-1:0] CNT_MAX = '1;

  state_t              state, state_nxt;
  logic                fil_end_q, rise, collect, inc, push, full, empty;
  logic                tot_zero, last_iter, q_bit;
  logic [ERR_BITS-1:0] tot_nxt, det_nxt, rem;
  logic [ERR_BITS:0]   rem_sh;
  logic [DW-1:0]       quo, q_fin;
  logic [IW-1:0]       iter;

  assign collect = (state == IDLE) || (state == COLLECT);
  assign rise    = collect && FIL_END && !fil_end_q;
  assign inc     = collect && FIL_INC;
  assign push    = inc && !DETECT;

  // Post-increment counts: a FIL_INC coincident with the FIL_END rise must
  // be included in the divide operands.
  assign tot_nxt  = (inc && TOT_COUNT != CNT_MAX) ? TOT_COUNT + 1'b1 : TOT_COUNT;
  assign det_nxt  = (inc && DETECT && DET_COUNT != CNT_MAX) ? DET_COUNT + 1'b1 : DET_COUNT;
  assign tot_zero = (tot_nxt == '0);

  // Restoring divide step. quo starts as the dividend and shifts out its MSB
  // into the remainder while quotient bits shift in at the LSB. TOT_COUNT is
  // frozen outside collection so it serves directly as the divisor.
  assign last_iter = (state == DIVIDE) && (iter == IW'(ITERS-1));
  assign rem_sh    = {rem, quo[DW-1]};
  assign q_bit     = (rem_sh >= {1'b0, TOT_COUNT});
  assign q_fin     = {quo[DW-2:0], q_bit};

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COLLECT: begin
        if (rise)     state_nxt = tot_zero ? FIN : DIVIDE;
        else if (inc) state_nxt = COLLECT;
      end
      DIVIDE:  if (last_iter) state_nxt = FIN;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fil_end_q <= 1'b0;
      TOT_COUNT <= '0;
      DET_COUNT <= '0;
      UNDET_OVF <= 1'b0;
      COVERAGE  <= '0;
      DONE      <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      iter      <= '0;
    end else begin
      fil_end_q <= FIL_END;
      if (collect) begin
        TOT_COUNT <= tot_nxt;
        DET_COUNT <= det_nxt;
      end
      if (push && full && !UNDET_POP) UNDET_OVF <= 1'b1;
      if (rise) begin
        quo  <= DW'(det_nxt) * DW'(PERMILLE);
        rem  <= '0;
        iter <= '0;
        if (tot_zero) begin
          COVERAGE <= '0;
          DONE     <= 1'b1;
        end
      end
      if (state == DIVIDE) begin
        quo  <= q_fin;
        rem  <= q_bit ? ERR_BITS'(rem_sh - {1'b0, TOT_COUNT}) : rem_sh[ERR_BITS-1:0];
        iter <= iter + 1'b1;
        if (last_iter) begin
          DONE     <= 1'b1;
          COVERAGE <= (q_fin > DW'(PERMILLE)) ? COV_BITS'(PERMILLE) : q_fin[COV_BITS-1:0];
        end
      end
    end
  end

  // Index pushed is the pre-increment total, i.e. the 0-based fault number.
  sync_fifo #(.WIDTH(ERR_BITS), .DEPTH(FIFO_DEPTH)) u_log (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (UNDET_POP),
    .din   (TOT_COUNT),
    .dout  (UNDET_IDX),
    .full  (full),
    .empty (empty)
  );

  assign UNDET_VALID = !empty;

endmodule

// File: tb/tb_coverage_reporter.sv
module tb_coverage_reporter;

  localparam int EB = 12, DEPTH = 16, CB = 10, MAX = (1 << EB) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic FIL_INC = 1'b0, DETECT = 1'b0, FIL_END = 1'b0, UNDET_POP = 1'b0;
  logic UNDET_VALID, UNDET_OVF, DONE;
  logic [EB-1:0] UNDET_IDX, DET_COUNT, TOT_COUNT;
  logic [CB-1:0] COVERAGE;

  logic inc4 = 1'b0, det4 = 1'b0, end4 = 1'b0, pop4 = 1'b0;
  logic v4, ovf4, done4;
  logic [3:0] idx4, detc4, totc4;
  logic [CB-1:0] cov4;

  coverage_reporter #(.ERR_BITS(EB), .FIFO_DEPTH(DEPTH), .COV_BITS(CB)) dut (
    .clk(clk), .rst(rst), .FIL_INC(FIL_INC), .DETECT(DETECT), .FIL_END(FIL_END),
    .UNDET_POP(UNDET_POP), .UNDET_VALID(UNDET_VALID), .UNDET_IDX(UNDET_IDX),
    .UNDET_OVF(UNDET_OVF), .DET_COUNT(DET_COUNT), .TOT_COUNT(TOT_COUNT),
    .COVERAGE(COVERAGE), .DONE(DONE));

  coverage_reporter #(.ERR_BITS(4), .FIFO_DEPTH(DEPTH), .COV_BITS(CB)) dut4 (
    .clk(clk), .rst(rst), .FIL_INC(inc4), .DETECT(det4), .FIL_END(end4),
    .UNDET_POP(pop4), .UNDET_VALID(v4), .UNDET_IDX(idx4),
    .UNDET_OVF(ovf4), .DET_COUNT(detc4), .TOT_COUNT(totc4),
    .COVERAGE(cov4), .DONE(done4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit v; int idx; } pop_t;
  typedef struct { int det; int tot; int cov; int lat; bit ovf; } res_t;

  pop_t exp_q[$];
  res_t res_q[$];
  int   total = 0, bad = 0;

  // Reference model state: counts, log contents, overflow, finished flag.
  int mq[$];
  int m_tot, m_det;
  bit m_ovf, m_fin, m_fend;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete(); res_q.delete();
    m_tot = 0; m_det = 0; m_ovf = 0; m_fin = 0; m_fend = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, UNDET_VALID, 0);
    chk({tag, "_idx"},   UNDET_IDX, 0);
    chk({tag, "_ovf"},   UNDET_OVF, 0);
    chk({tag, "_det"},   DET_COUNT, 0);
    chk({tag, "_tot"},   TOT_COUNT, 0);
    chk({tag, "_cov"},   COVERAGE, 0);
    chk({tag, "_done"},  DONE, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; FIL_INC = 0; DETECT = 0; FIL_END = 0; UNDET_POP = 0;
    inc4 = 0; det4 = 0; end4 = 0; pop4 = 0;
    #2;
    check_zero("rst");
    chk("rst4_tot", totc4, 0);
    chk("rst4_done", done4, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One clock of stimulus; the model applies the same cycle's effects:
  // pop first (frees a slot), then push/count, then the FIL_END rise.
  task automatic step(input bit inc, input bit det, input bit pop, input bit fend);
    pop_t p;
    res_t r;
    @(posedge clk); #1;
    FIL_INC = inc; DETECT = det; UNDET_POP = pop; FIL_END = fend;
    if (pop) begin
      p.v = (mq.size() > 0);
      p.idx = p.v ? mq.pop_front() : 0;
      exp_q.push_back(p);
    end
    if (inc && !m_fin) begin
      if (det) m_det = (m_det < MAX) ? m_det + 1 : MAX;
      else if (mq.size() < DEPTH) mq.push_back(m_tot);
      else m_ovf = 1;
      m_tot = (m_tot < MAX) ? m_tot + 1 : MAX;
    end
    if (fend && !m_fend && !m_fin) begin
      m_fin = 1;
      r.det = m_det; r.tot = m_tot; r.ovf = m_ovf;
      r.cov = (m_tot == 0) ? 0 : (m_det * 1000) / m_tot;
      if (r.cov > 1000) r.cov = 1000;
      r.lat = (m_tot == 0) ? 1 : EB + CB + 1;
      res_q.push_back(r);
    end
    m_fend = fend;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int k = 0;
    while (res_q.size() != 0 && k < budget) begin
      if (rnd) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0, 1);
      else     step(0, 0, 0, 1);
      k++;
    end
    if (res_q.size() != 0) begin
      chk("done_timeout", res_q.size(), 0);
      res_q.delete();
    end
  endtask

  task automatic drain();
    while (mq.size() > 0) step(0, 0, 1, FIL_END);
    step(0, 0, 1, FIL_END);   // pop on an empty log: must be ignored
    step(0, 0, 0, FIL_END);
  endtask

  task automatic t1_body();
    bit [7:0] pat = 8'b1011_1011;   // sent LSB first: 1,1,0,1,1,1,0,1
    for (int i = 0; i < 8; i++) step(1, pat[i], 0, 0);
    step(0, 0, 0, 1);
    wait_done(40, 0);
    chk("t1_done_hold", DONE, 1);
    drain();
  endtask

  // Scoreboard monitor: checks pops and the DONE-time results.
  int   t0;
  bit   fe_prev, done_prev;
  pop_t mon_p;
  res_t mon_r;
  always @(negedge clk) begin
    if (rst) begin
      fe_prev = 0; done_prev = 0;
    end else begin
      if (FIL_END && !fe_prev) t0 = cyc;
      if (UNDET_POP) begin
        if (exp_q.size() == 0) chk("pop_unexpected", exp_q.size(), 1);
        else begin
          mon_p = exp_q.pop_front();
          chk("undet_valid", UNDET_VALID, mon_p.v);
          if (mon_p.v) chk("undet_idx", UNDET_IDX, mon_p.idx);
        end
      end
      if (DONE && !done_prev) begin
        if (res_q.size() == 0) chk("done_unexpected", DONE, 0);
        else begin
          mon_r = res_q.pop_front();
          chk("coverage", COVERAGE, mon_r.cov);
          chk("det_count", DET_COUNT, mon_r.det);
          chk("tot_count", TOT_COUNT, mon_r.tot);
          chk("undet_ovf", UNDET_OVF, mon_r.ovf);
          chk("done_latency", cyc - t0, mon_r.lat);
        end
      end
      fe_prev = FIL_END; done_prev = DONE;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, dp, lat;
    bit pr;

    // T1: basic pattern -> 750 permille, log holds 2 and 6
    do_reset();
    t1_body();

    // T2: FIL_END with no faults
    do_reset();
    step(0, 0, 0, 1);
    wait_done(10, 0);
    chk("t2_valid", UNDET_VALID, 0);
    drain();

    // T3: log fill, pop+push while full, then overflow
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t3_ovf_poppush", UNDET_OVF, 0);
    chk("t3_valid_full", UNDET_VALID, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_ovf_set", UNDET_OVF, 1);
    step(0, 0, 0, 1);
    wait_done(40, 0);
    drain();

    // T4: fault coincident with FIL_END rise is counted
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    wait_done(40, 0);

    // T5: reset mid-divide, then rerun T1
    do_reset();
    for (int i = 0; i < 8; i++) step(1, i[0], 0, 0);
    step(0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);
    @(posedge clk); #3;
    rst = 1; FIL_END = 0;
    #1;
    check_zero("t5_abort");
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    t1_body();

    // Randomized runs against the reference model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n  = $urandom_range(0, 40);
      dp = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) step(0, 0, $urandom_range(0, 3) == 0, 0);
        pr = ($urandom_range(0, 3) == 0);
        step(1, $urandom_range(0, 3) < dp, pr, 0);
      end
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0, 1);
      wait_done(60, 1);
      chk("rnd_ovf", UNDET_OVF, m_ovf);
      drain();
      chk("rnd_done_hold", DONE, 1);
    end

    // T6: ERR_BITS=4 instance saturates at 15
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1; inc4 = 1; det4 = 1;
    end
    @(posedge clk); #1; inc4 = 0; end4 = 1;
    lat = 0;
    @(negedge clk);
    while (!done4 && lat < 40) begin @(negedge clk); lat++; end
    chk("t6_latency", lat, 4 + CB + 1);
    chk("t6_tot", totc4, 15);
    chk("t6_det", detc4, 15);
    chk("t6_cov", cov4, 1000);
    chk("t6_valid", v4, 0);
    chk("t6_ovf", ovf4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
